// File: rtl/ucsbece154b_dmem_arbiter.sv
// Data-memory arbiter: round-robin between the core (C) and loader (D) ports,
// with a bounded locked-burst mode that lets D hold the memory while C waits.
module ucsbece154b_dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_valid_i,
    input  logic          c_we_i,
    input  logic [AW-1:0] c_addr_i,
    input  logic [DW-1:0] c_wd_i,
    output logic          c_ready_o,
    output logic [DW-1:0] c_rd_o,
    input  logic          d_valid_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wd_i,
    input  logic          d_lock_i,
    output logic          d_ready_o,
    output logic [DW-1:0] d_rd_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_a_o,
    output logic [DW-1:0] mem_wd_o,
    input  logic [DW-1:0] mem_rd_i,
    output logic [1:0]    owner_o
);

    typedef enum logic [1:0] {IDLE, LAST_C, LAST_D, D_BURST} state_t;

    localparam logic [7:0] MAXB = 8'(MAX_BURST);

    state_t     state_q, state_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic       grant_c, grant_d;
    logic       burst_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        grant_c    = 1'b0;
        grant_d    = 1'b0;
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        burst_hold = (state_q == D_BURST) && d_valid_i && d_lock_i && (bcnt_q < MAXB);

        if (!reset) begin
            grant_c = 1'b0;
            grant_d = 1'b0;
        end else if (burst_hold) begin
            grant_d = 1'b0 | 1'b1;
            if (c_valid_i) bcnt_d = 8'(bcnt_q + 8'd1);
        end else begin
            // Leaving D_BURST falls back to LAST_D priority in the same cycle.
            if (c_valid_i && d_valid_i) begin
                grant_c = (state_q != LAST_C);
                grant_d = (state_q == LAST_C);
            end else begin
                grant_c = c_valid_i;
                grant_d = d_valid_i;
            end

            if (grant_c) begin
                state_d = LAST_C;
                bcnt_d  = 8'd0;
            end else if (grant_d) begin
                if (d_lock_i) begin
                    // The opening grant only counts if C is already waiting.
                    state_d = D_BURST;
                    bcnt_d  = {7'd0, c_valid_i};
                end else begin
                    state_d = LAST_D;
                    bcnt_d  = 8'd0;
                end
            end else if (state_q == D_BURST) begin
                state_d = LAST_D;
                bcnt_d  = 8'd0;
            end
        end
    end

    always_comb begin
        c_ready_o = grant_c;
        d_ready_o = grant_d;
        c_rd_o    = grant_c ? mem_rd_i : '0;
        d_rd_o    = grant_d ? mem_rd_i : '0;
        owner_o   = {grant_d, grant_c};
        mem_we_o  = 1'b0;
        mem_a_o   = '0;
        mem_wd_o  = '0;
        if (grant_c) begin
            mem_we_o = c_we_i;
            mem_a_o  = c_addr_i;
            mem_wd_o = c_wd_i;
        end else if (grant_d) begin
            mem_we_o = d_we_i;
            mem_a_o  = d_addr_i;
            mem_wd_o = d_wd_i;
        end
    end

endmodule

// File: tb/tb_ucsbece154b_dmem_arbiter.sv
// Scoreboard bench for the data-memory arbiter: the driver queues the expected
// per-cycle response, a negedge monitor pops and compares it.
module tb_ucsbece154b_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        c_valid_i = 1'b0, c_we_i = 1'b0;
    logic [31:0] c_addr_i = '0, c_wd_i = '0;
    logic        c_ready_o;
    logic [31:0] c_rd_o;
    logic        d_valid_i = 1'b0, d_we_i = 1'b0, d_lock_i = 1'b0;
    logic [31:0] d_addr_i = '0, d_wd_i = '0;
    logic        d_ready_o;
    logic [31:0] d_rd_o;
    logic        mem_we_o;
    logic [31:0] mem_a_o, mem_wd_o;
    logic [31:0] mem_rd_i = '0;
    logic [1:0]  owner_o;

    ucsbece154b_dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .c_valid_i(c_valid_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wd_i(c_wd_i),
        .c_ready_o(c_ready_o), .c_rd_o(c_rd_o),
        .d_valid_i(d_valid_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wd_i(d_wd_i),
        .d_lock_i(d_lock_i), .d_ready_o(d_ready_o), .d_rd_o(d_rd_o),
        .mem_we_o(mem_we_o), .mem_a_o(mem_a_o), .mem_wd_o(mem_wd_o),
        .mem_rd_i(mem_rd_i), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  own;
        logic        cr, dr, we;
        logic [31:0] a, wd, crd, drd;
        logic [15:0] tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] c_next = 32'h200, d_next = 32'h100, rd_next = 32'h5000;

    task automatic chk(input string name, input logic [15:0] tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("owner",   e.tag, {30'd0, owner_o},   {30'd0, e.own});
            chk("c_ready", e.tag, {31'd0, c_ready_o}, {31'd0, e.cr});
            chk("d_ready", e.tag, {31'd0, d_ready_o}, {31'd0, e.dr});
            chk("mem_we",  e.tag, {31'd0, mem_we_o},  {31'd0, e.we});
            chk("mem_a",   e.tag, mem_a_o,  e.a);
            chk("mem_wd",  e.tag, mem_wd_o, e.wd);
            chk("c_rd",    e.tag, c_rd_o,   e.crd);
            chk("d_rd",    e.tag, d_rd_o,   e.drd);
        end
    end

    int vec = 0;

    // Drive one cycle and queue the response implied by the hand-derived owner.
    task automatic step(input logic rst, input logic cv, input logic cwe, input logic [31:0] ca,
                        input logic [31:0] cwd, input logic dv, input logic dwe, input logic dl,
                        input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] rdv,
                        input logic [1:0] own);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        c_valid_i = cv; c_we_i = cwe; c_addr_i = ca; c_wd_i = cwd;
        d_valid_i = dv; d_we_i = dwe; d_lock_i = dl; d_addr_i = da; d_wd_i = dwd;
        mem_rd_i = rdv;
        e.own = own;
        e.cr  = (own == 2'b01);
        e.dr  = (own == 2'b10);
        e.we  = e.cr ? cwe : (e.dr ? dwe : 1'b0);
        e.a   = e.cr ? ca  : (e.dr ? da  : 32'd0);
        e.wd  = e.cr ? cwd : (e.dr ? dwd : 32'd0);
        e.crd = e.cr ? rdv : 32'd0;
        e.drd = e.dr ? rdv : 32'd0;
        e.tag = 16'(vec);
        vec++;
        q.push_back(e);
    endtask

    // C issues loads, D issues stores; a port's address advances only after its grant.
    task automatic go(input logic rst, input logic cv, input logic dv, input logic dl, input logic [1:0] own);
        step(rst, cv, 1'b0, c_next, 32'h0, dv, 1'b1, dl, d_next, d_next ^ 32'hA000_0000, rd_next, own);
        rd_next = rd_next + 32'd1;
        if (own == 2'b01) c_next = c_next + 32'd4;
        if (own == 2'b10) d_next = d_next + 32'd4;
    endtask

    initial begin
        // Reset held with both requesters active: nothing granted.
        step(1'b0, 1'b1, 1'b1, 32'h40, 32'h11, 1'b1, 1'b1, 1'b0, 32'h80, 32'h22, 32'h1234, 2'b00);
        // First cycle after release: core load of 0x40.
        step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 2'b01);

        // Back to IDLE, then alternate C,D,C,D,C,D with no lock.
        go(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 6; k++) go(1'b1, 1'b1, 1'b1, 1'b0, (k % 2 == 0) ? 2'b01 : 2'b10);

        // From LAST_D C wins, then D opens a locked burst: 8 D grants, then C.
        go(1'b1, 1'b1, 1'b1, 1'b1, 2'b01);
        for (int k = 0; k < 8; k++) go(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        go(1'b1, 1'b1, 1'b1, 1'b1, 2'b01);

        // Uncontended lock for 20 cycles, then C waits through 8 counted D grants.
        for (int k = 0; k < 20; k++) go(1'b1, 1'b0, 1'b1, 1'b1, 2'b10);
        for (int k = 0; k < 8; k++) go(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        go(1'b1, 1'b1, 1'b1, 1'b1, 2'b01);

        // Reset in the third burst cycle, then C wins first from IDLE.
        go(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        go(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        go(1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
        go(1'b1, 1'b1, 1'b1, 1'b1, 2'b01);

        // Lock drops mid-burst: C wins that cycle, and LAST_C then favours D.
        go(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        go(1'b1, 1'b1, 1'b1, 1'b1, 2'b10);
        go(1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
        go(1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
        go(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
